hc74_arb: RTL and testbench

Sequencer and two-way arbiter for one external dual D flip-flop (HC74-style: two channels, each with active-low set and clear, data and rising-edge clock). Two requesters issue SET, CLR, LOAD or NOP commands to either channel. The block arbitrates between them round-robin and drives the pins with programmed setup and hold spacing. On completion it acknowledges the requester and updates a shadow copy of the flip-flop state. It sits between the control logic and the HC74 pad ring.

---
 rtl/hc74_arb_pkg.sv | 23 ++
 rtl/rr_arb2.sv | 25 ++
 rtl/hc74_arb.sv | 181 ++++++++++++++++++
 tb/tb_hc74_arb.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/hc74_arb_pkg.sv
// Shared types and defaults for the hc74_arb HC74 sequencer/arbiter.
package hc74_arb_pkg;

  localparam int DEF_SETTLE = 2;
  localparam int DEF_HOLD   = 1;

  typedef enum logic [1:0] {
    OP_NOP  = 2'b00,
    OP_SET  = 2'b01,
    OP_CLR  = 2'b10,
    OP_LOAD = 2'b11
  } op_e;

  typedef enum logic [2:0] {
    ST_INIT,
    ST_IDLE,
    ST_SETUP,
    ST_STROBE,
    ST_RELEASE,
    ST_ACK
  } state_e;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter: the pointer wins ties and moves past each winner.
module rr_arb2 (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic [1:0] i_req,
  input  logic       i_advance,
  output logic [1:0] o_grant,
  output logic       o_ptr
);

  logic r_ptr;

  always_comb begin
    o_grant = i_req;
    if (i_req == 2'b11) o_grant = r_ptr ? 2'b10 : 2'b01;
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst)                     r_ptr <= 1'b0;
    else if (i_advance && |i_req)  r_ptr <= ~o_grant[1];
  end

  assign o_ptr = r_ptr;

endmodule

// File: rtl/hc74_arb.sv
// Sequencer and two-requester arbiter driving one HC74 dual D flip-flop.
// Define HC74_ARB_READBACK_EN to add the shadow state (Q1, Q2, Rdata).
module hc74_arb
  import hc74_arb_pkg::*;
#(
  parameter int SETTLE_CYCLES = DEF_SETTLE,
  parameter int HOLD_CYCLES   = DEF_HOLD
) (
  input  logic       Clk,
  input  logic       Rst,
  input  logic [1:0] Req,
  input  logic [1:0] Op0,
  input  logic [1:0] Op1,
  input  logic       Ch0,
  input  logic       Ch1,
  input  logic       Din0,
  input  logic       Din1,
  output logic       S1,
  output logic       R1,
  output logic       D1,
  output logic       Ck1,
  output logic       S2,
  output logic       R2,
  output logic       D2,
  output logic       Ck2,
`ifdef HC74_ARB_READBACK_EN
  output logic       Q1,
  output logic       Q2,
  output logic       Rdata,
`endif
  output logic [1:0] Ack,
  output logic       Busy
);

  localparam int MAX_CYC = (SETTLE_CYCLES > HOLD_CYCLES) ? SETTLE_CYCLES : HOLD_CYCLES;
  localparam int CNT_W   = $clog2(MAX_CYC + 1);
  localparam logic [CNT_W-1:0] SETTLE_LD = CNT_W'(SETTLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] HOLD_LD   = CNT_W'(HOLD_CYCLES - 1);

  state_e           r_state, w_state_nx;
  logic [CNT_W-1:0] r_cnt, w_cnt_nx;
  op_e              r_op, w_op_nx;
  logic             r_ch, w_ch_nx;
  logic             r_din, w_din_nx;
  logic             r_gnt, w_gnt_nx;
  logic [1:0]       w_grant;
  logic             w_advance;
  logic             w_unused_ptr;
  logic             w_strobe_nx;
  logic             r_s1, r_r1, r_d1, r_ck1;
  logic             r_s2, r_r2, r_d2, r_ck2;
  logic [1:0]       r_ack;

  rr_arb2 u_arb (
    .i_clk     (Clk),
    .i_rst     (Rst),
    .i_req     (Req),
    .i_advance (w_advance),
    .o_grant   (w_grant),
    .o_ptr     (w_unused_ptr)
  );

  // NOTE: every signal gets a default before the case so no path leaves one unassigned (no latches).
  always_comb begin
    w_state_nx = r_state;
    w_cnt_nx   = (r_cnt != '0) ? r_cnt - 1'b1 : '0;
    w_op_nx    = r_op;
    w_ch_nx    = r_ch;
    w_din_nx   = r_din;
    w_gnt_nx   = r_gnt;
    w_advance  = 1'b0;
    case (r_state)
      ST_INIT:    if (r_cnt == '0) w_state_nx = ST_IDLE;
      ST_IDLE: begin
        if (|Req) begin
          w_advance = 1'b1;
          w_gnt_nx  = w_grant[1];
          w_op_nx   = op_e'(w_grant[1] ? Op1 : Op0);
          w_ch_nx   = w_grant[1] ? Ch1 : Ch0;
          w_din_nx  = w_grant[1] ? Din1 : Din0;
          if (w_op_nx == OP_NOP) begin
            w_state_nx = ST_ACK;
          end else begin
            w_state_nx = ST_SETUP;
            w_cnt_nx   = SETTLE_LD;
          end
        end
      end
      ST_SETUP: begin
        if (r_cnt == '0) begin
          w_state_nx = ST_STROBE;
          w_cnt_nx   = HOLD_LD;
        end
      end
      ST_STROBE:  if (r_cnt == '0) w_state_nx = ST_RELEASE;
      ST_RELEASE: w_state_nx = ST_ACK;
      ST_ACK:     w_state_nx = ST_IDLE;
      default:    w_state_nx = ST_INIT;
    endcase
  end

  assign w_strobe_nx = (w_state_nx == ST_STROBE);

  // Pins are decoded from next-state values, so they stay registered yet align with their state.
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      r_state <= ST_INIT;
      r_cnt   <= HOLD_LD;
      r_op    <= OP_NOP;
      r_ch    <= 1'b0;
      r_din   <= 1'b0;
      r_gnt   <= 1'b0;
      r_s1    <= 1'b1;
      r_r1    <= 1'b0;
      r_d1    <= 1'b0;
      r_ck1   <= 1'b0;
      r_s2    <= 1'b1;
      r_r2    <= 1'b0;
      r_d2    <= 1'b0;
      r_ck2   <= 1'b0;
      r_ack   <= 2'b00;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      r_state <= w_state_nx;
      r_cnt   <= w_cnt_nx;
      r_op    <= w_op_nx;
      r_ch    <= w_ch_nx;
      r_din   <= w_din_nx;
      r_gnt   <= w_gnt_nx;
      r_s1    <= !(w_strobe_nx && w_op_nx == OP_SET && !w_ch_nx);
      r_r1    <= (w_state_nx != ST_INIT) && !(w_strobe_nx && w_op_nx == OP_CLR && !w_ch_nx);
      r_ck1   <= w_strobe_nx && w_op_nx == OP_LOAD && !w_ch_nx;
      r_s2    <= !(w_strobe_nx && w_op_nx == OP_SET && w_ch_nx);
      r_r2    <= (w_state_nx != ST_INIT) && !(w_strobe_nx && w_op_nx == OP_CLR && w_ch_nx);
      r_ck2   <= w_strobe_nx && w_op_nx == OP_LOAD && w_ch_nx;
      if (w_state_nx == ST_SETUP && w_op_nx == OP_LOAD && !w_ch_nx) r_d1 <= w_din_nx;
      if (w_state_nx == ST_SETUP && w_op_nx == OP_LOAD &&  w_ch_nx) r_d2 <= w_din_nx;
      r_ack   <= (w_state_nx == ST_ACK) ? (w_gnt_nx ? 2'b10 : 2'b01) : 2'b00;
    end
  end

`ifdef HC74_ARB_READBACK_EN
  logic r_q1, r_q2, r_rdata, w_new_q;

  always_comb begin
    w_new_q = r_din;
    if (r_op == OP_SET)      w_new_q = 1'b1;
    else if (r_op == OP_CLR) w_new_q = 1'b0;
  end

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      r_q1    <= 1'b0;
      r_q2    <= 1'b0;
      r_rdata <= 1'b0;
    end else if (r_state == ST_RELEASE) begin
      if (r_ch) r_q2 <= w_new_q;
      else      r_q1 <= w_new_q;
      r_rdata <= w_new_q;
    end else if (r_state == ST_IDLE && w_state_nx == ST_ACK) begin
      r_rdata <= w_ch_nx ? r_q2 : r_q1;
    end
  end

  assign Q1    = r_q1;
  assign Q2    = r_q2;
  assign Rdata = r_rdata;
`endif

  assign S1   = r_s1;
  assign R1   = r_r1;
  assign D1   = r_d1;
  assign Ck1  = r_ck1;
  assign S2   = r_s2;
  assign R2   = r_r2;
  assign D2   = r_d2;
  assign Ck2  = r_ck2;
  assign Ack  = r_ack;
  assign Busy = (r_state != ST_IDLE);

endmodule

// File: tb/tb_hc74_arb.sv
// Self-checking bench for hc74_arb: vector table, hand sequences and a randomized run.
module tb_hc74_arb;
  import hc74_arb_pkg::*;

  localparam int SETTLE = 2;
  localparam int HOLD   = 1;
  localparam int LAT    = SETTLE + HOLD + 2;

  logic       Clk = 1'b0;
  logic       Rst = 1'b1;
  logic [1:0] Req = 2'b00;
  logic [1:0] Op0 = 2'b00, Op1 = 2'b00;
  logic       Ch0 = 1'b0, Ch1 = 1'b0, Din0 = 1'b0, Din1 = 1'b0;
  logic [1:0] Ack;
  logic       Busy;
  logic       S1, R1, D1, Ck1, S2, R2, D2, Ck2;
`ifdef HC74_ARB_READBACK_EN
  logic       Q1, Q2, Rdata;
`endif

  hc74_arb #(.SETTLE_CYCLES(SETTLE), .HOLD_CYCLES(HOLD)) dut (
    .Clk   (Clk),
    .Rst   (Rst),
    .Req   (Req),
    .Op0   (Op0),
    .Op1   (Op1),
    .Ch0   (Ch0),
    .Ch1   (Ch1),
    .Din0  (Din0),
    .Din1  (Din1),
    .S1    (S1),
    .R1    (R1),
    .D1    (D1),
    .Ck1   (Ck1),
    .S2    (S2),
    .R2    (R2),
    .D2    (D2),
    .Ck2   (Ck2),
`ifdef HC74_ARB_READBACK_EN
    .Q1    (Q1),
    .Q2    (Q2),
    .Rdata (Rdata),
`endif
    .Ack   (Ack),
    .Busy  (Busy)
  );

  always #5 Clk = ~Clk;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model state: index 0 = channel 1, index 1 = channel 2.
  bit       m_ptr = 1'b0;
  bit [1:0] m_d   = 2'b00;
  bit [1:0] m_q   = 2'b00;

  logic [1:0] t_op  [2];
  logic       t_ch  [2];
  logic       t_din [2];

  typedef struct {
    logic [1:0] req;
    logic [1:0] op0, op1;
    logic       ch0, ch1, din0, din1;
    int         lat;
    logic [1:0] ack;
    logic [1:0] q;
  } vec_t;

  vec_t vecs [9];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [7:0] pins_now();
    return {S1, R1, D1, Ck1, S2, R2, D2, Ck2};
  endfunction

  function automatic logic [7:0] pack(bit [1:0] s, bit [1:0] r, bit [1:0] d, bit [1:0] ck);
    return {s[0], r[0], d[0], ck[0], s[1], r[1], d[1], ck[1]};
  endfunction

  task automatic drive_fields();
    Op0 = t_op[0]; Op1 = t_op[1];
    Ch0 = t_ch[0]; Ch1 = t_ch[1];
    Din0 = t_din[0]; Din1 = t_din[1];
  endtask

  // Called at a negedge while the DUT is idle; ends at the negedge of the following idle cycle.
  task automatic do_txn(input logic [1:0] req, input bit drop, output int first_k, output logic [1:0] ack_seen);
    int w, c, lat;
    logic [1:0] op, exp_ack;
    bit [1:0] s, r, ck;
    first_k  = 0;
    ack_seen = 2'b00;
    Req = req;
    drive_fields();
    if (req == 2'b00) begin
      @(negedge Clk);
      check("no_req_idle", {Ack, Busy}, 3'b000);
      return;
    end
    w     = (req == 2'b11) ? int'(m_ptr) : (req[1] ? 1 : 0);
    m_ptr = (w == 0);
    op    = t_op[w];
    c     = int'(t_ch[w]);
    lat   = (op == OP_NOP) ? 1 : LAT;
    for (int k = 1; k <= lat; k++) begin
      s = 2'b11; r = 2'b11; ck = 2'b00;
      @(negedge Clk);
      if (op == OP_LOAD && k == 1) m_d[c] = t_din[w];
      if (op != OP_NOP && k > SETTLE && k <= SETTLE + HOLD) begin
        case (op)
          OP_SET:  s[c]  = 1'b0;
          OP_CLR:  r[c]  = 1'b0;
          OP_LOAD: ck[c] = 1'b1;
          default: ;
        endcase
      end
      if (k == lat) begin
        case (op)
          OP_SET:  m_q[c] = 1'b1;
          OP_CLR:  m_q[c] = 1'b0;
          OP_LOAD: m_q[c] = t_din[w];
          default: ;
        endcase
      end
      exp_ack = (k == lat) ? ((w == 1) ? 2'b10 : 2'b01) : 2'b00;
      check("txn_pins", pins_now(), pack(s, r, m_d, ck));
      check("txn_ack_busy", {Ack, Busy}, {exp_ack, 1'b1});
      if (Ack != 2'b00 && first_k == 0) begin
        first_k  = k;
        ack_seen = Ack;
      end
`ifdef HC74_ARB_READBACK_EN
      if (k == lat) begin
        check("txn_rdata", Rdata, m_q[c]);
        check("txn_shadow", {Q2, Q1}, m_q);
      end
`endif
      if (drop && k == 1) Req[w] = 1'b0;
    end
    Req[w] = 1'b0;
    @(negedge Clk);
    check("idle_after_ack", {Ack, Busy}, 3'b000);
  endtask

  initial begin
    int fk;
    logic [1:0] ak;
    logic [1:0] rq;

    t_op = '{OP_NOP, OP_NOP}; t_ch = '{1'b0, 1'b0}; t_din = '{1'b0, 1'b0};
    //            req    op0      op1      ch0 ch1 d0 d1 lat  ack    q{Q2,Q1}
    vecs[0] = '{2'b11, OP_SET,  OP_SET,  1, 1, 0, 0, LAT, 2'b01, 2'b10};
    vecs[1] = '{2'b10, OP_SET,  OP_SET,  1, 1, 0, 0, LAT, 2'b10, 2'b10};
    vecs[2] = '{2'b01, OP_LOAD, OP_SET,  0, 1, 1, 0, LAT, 2'b01, 2'b11};
    vecs[3] = '{2'b10, OP_LOAD, OP_CLR,  0, 0, 1, 0, LAT, 2'b10, 2'b10};
    vecs[4] = '{2'b01, OP_NOP,  OP_CLR,  1, 0, 0, 0, 1,   2'b01, 2'b10};
    vecs[5] = '{2'b11, OP_NOP,  OP_LOAD, 1, 1, 0, 0, LAT, 2'b10, 2'b00};
    vecs[6] = '{2'b01, OP_NOP,  OP_LOAD, 1, 1, 0, 0, 1,   2'b01, 2'b00};
    vecs[7] = '{2'b00, OP_NOP,  OP_NOP,  0, 0, 0, 0, 0,   2'b00, 2'b00};
    vecs[8] = '{2'b10, OP_NOP,  OP_LOAD, 0, 1, 0, 1, LAT, 2'b10, 2'b10};

    // Reset values, then one INIT cycle with R low, then IDLE.
    repeat (3) @(negedge Clk);
    check("rst_pins", pins_now(), 8'b1000_1000);
    check("rst_ack_busy", {Ack, Busy}, 3'b001);
`ifdef HC74_ARB_READBACK_EN
    check("rst_shadow", {Q2, Q1, Rdata}, 3'b000);
`endif
    @(posedge Clk); #1 Rst = 1'b0;
    @(negedge Clk);
    check("init_pins", pins_now(), 8'b1000_1000);
    check("init_busy", {Ack, Busy}, 3'b001);
    @(negedge Clk);
    check("idle_pins", pins_now(), 8'b1100_1100);
    check("idle_busy", {Ack, Busy}, 3'b000);

    for (int i = 0; i < 9; i++) begin
      t_op[0] = vecs[i].op0;  t_op[1] = vecs[i].op1;
      t_ch[0] = vecs[i].ch0;  t_ch[1] = vecs[i].ch1;
      t_din[0] = vecs[i].din0; t_din[1] = vecs[i].din1;
      do_txn(vecs[i].req, 1'b0, fk, ak);
      check("vec_latency", fk, vecs[i].lat);
      check("vec_ack", ak, vecs[i].ack);
`ifdef HC74_ARB_READBACK_EN
      check("vec_shadow", {Q2, Q1}, vecs[i].q);
`endif
    end

    // Req dropped right after the grant: the transaction still completes and acks.
    t_op[1] = OP_SET; t_ch[1] = 1'b0; t_din[1] = 1'b0;
    do_txn(2'b10, 1'b1, fk, ak);
    check("drop_latency", fk, LAT);
    check("drop_ack", ak, 2'b10);

    for (int i = 0; i < 40; i++) begin
      for (int j = 0; j < 2; j++) begin
        if (Req[j]) begin
          rq[j] = 1'b1;
        end else begin
          rq[j]    = ($urandom_range(0, 3) != 0);
          t_op[j]  = 2'($urandom_range(0, 3));
          t_ch[j]  = 1'($urandom_range(0, 1));
          t_din[j] = 1'($urandom_range(0, 1));
        end
      end
      do_txn(rq, ($urandom_range(0, 3) == 0), fk, ak);
    end
    if (Req != 2'b00) do_txn(Req, 1'b0, fk, ak);

    // Reset during the strobe of a LOAD on channel 2.
    t_op[0] = OP_LOAD; t_ch[0] = 1'b1; t_din[0] = 1'b1;
    Req = 2'b01;
    drive_fields();
    repeat (SETTLE + 1) @(negedge Clk);
    check("mid_strobe_ck2", Ck2, 1'b1);
    Rst = 1'b1;
    #1;
    check("mid_rst_pins", pins_now(), 8'b1000_1000);
    check("mid_rst_ack_busy", {Ack, Busy}, 3'b001);
`ifdef HC74_ARB_READBACK_EN
    check("mid_rst_shadow", {Q2, Q1, Rdata}, 3'b000);
`endif
    Req = 2'b00;
    m_ptr = 1'b0; m_d = 2'b00; m_q = 2'b00;
    @(posedge Clk); #1 Rst = 1'b0;
    @(negedge Clk);
    check("reinit_pins", pins_now(), 8'b1000_1000);
    check("reinit_busy", {Ack, Busy}, 3'b001);
    @(negedge Clk);
    check("reidle_pins", pins_now(), 8'b1100_1100);
    check("reidle_busy", {Ack, Busy}, 3'b000);

    // Pointer must be back at requester 0 after reset.
    t_op[0] = OP_SET; t_ch[0] = 1'b0; t_op[1] = OP_CLR; t_ch[1] = 1'b1;
    do_txn(2'b11, 1'b0, fk, ak);
    check("ptr_after_rst", ak, 2'b01);
    do_txn(Req, 1'b0, fk, ak);
    check("ptr_second", ak, 2'b10);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
